// File: rtl/data_mem_responder_if.sv
// Load/store bus between the CPU memory stage (master) and a data memory (slave).
// Handshake: master raises req with we/addr/sel/wdata and holds all of them stable until
// it sees a one-cycle ack or err; the slave completes each accepted request with exactly one of them.
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, we, addr, sel, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack, err);
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with programmable wait states, single-cycle ack/err completion
// and big-endian byte-select writes. fsm_state exposes the FSM: 0 = IDLE, 1 = WAIT, 2 = RESP.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           fsm_state
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]            cnt_q;
  logic                  we_q;
  logic                  hit_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        err_q;

  logic                  bus_hit;
  logic                  accept;
  logic                  commit;
  logic                  op_we;
  logic                  op_hit;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic [3:0]            op_sel;
  logic [31:0]           op_wdata;
  logic                  mem_wr;
  logic                  mem_rd;
  logic                  resp_ok;
  logic                  resp_err;
  logic                  unused_addr_bits;

  assign bus_hit          = (bus.addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign unused_addr_bits = ^bus.addr[1:0];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.req) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!bus.req)          state_d = S_IDLE;
        else if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control logic. With zero wait states the request commits on its acceptance
  // edge, before the latches hold it, so the live bus fields are used while in IDLE.
  always_comb begin
    accept   = (state_q == S_IDLE) && bus.req;
    commit   = rst && (state_d == S_RESP) && (state_q != S_RESP);
    op_we    = (state_q == S_IDLE) ? bus.we    : we_q;
    op_hit   = (state_q == S_IDLE) ? bus_hit   : hit_q;
    op_idx   = (state_q == S_IDLE) ? bus.addr[ADDR_WIDTH+1:2] : idx_q;
    op_sel   = (state_q == S_IDLE) ? bus.sel   : sel_q;
    op_wdata = (state_q == S_IDLE) ? bus.wdata : wdata_q;
    mem_wr   = commit && op_hit && op_we;
    mem_rd   = commit && op_hit && !op_we;
    resp_ok  = commit && op_hit;
    resp_err = commit && !op_hit;
  end

  // Request latches and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      cnt_q   <= WAIT_INIT;
      we_q    <= bus.we;
      hit_q   <= bus_hit;
      idx_q   <= bus.addr[ADDR_WIDTH+1:2];
      sel_q   <= bus.sel;
      wdata_q <= bus.wdata;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Array kept reset-free so it can map onto block RAM; sel[b] guards wdata[8b+7:8b].
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (op_sel[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

  // Response registers: high only in the RESP cycle, rdata held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= resp_ok;
      err_q <= resp_err;
      if (mem_rd)        rdata_q <= mem[op_idx];
      else if (resp_err) rdata_q <= 32'd0;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 3 and 0 wait states) driven from shared
// tasks, directed vector table, multi-cycle corner sequences and a randomized model comparison.
module tb_data_mem_responder;

  localparam int NI = 3;
  localparam logic [1:0] IDLE_CODE = 2'd0;

  logic        clk;
  logic        rst;
  logic        req_v   [NI];
  logic        we_v    [NI];
  logic [31:0] addr_v  [NI];
  logic [3:0]  sel_v   [NI];
  logic [31:0] wdata_v [NI];
  wire  [31:0] rdata_v [NI];
  wire         ack_v   [NI];
  wire         err_v   [NI];
  wire  [1:0]  state_v [NI];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int unsigned WC = (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    data_mem_responder_if bus ();
    assign bus.req     = req_v[k];
    assign bus.we      = we_v[k];
    assign bus.addr    = addr_v[k];
    assign bus.sel     = sel_v[k];
    assign bus.wdata   = wdata_v[k];
    assign rdata_v[k]  = bus.rdata;
    assign ack_v[k]    = bus.ack;
    assign err_v[k]    = bus.err;
    data_mem_responder #(
      .ADDR_WIDTH (10),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_CYCLES(WC)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .fsm_state(state_v[k])
    );
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; called and returns at #1 after a rising edge.
  task automatic do_txn(input int k, input bit wr, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output bit got_ack, output bit got_err,
                        output logic [31:0] rd, output int lat);
    we_v[k] = wr; addr_v[k] = a; sel_v[k] = s; wdata_v[k] = d; req_v[k] = 1'b1;
    got_ack = 1'b0; got_err = 1'b0; rd = 32'd0; lat = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      lat++;
      if (ack_v[k] || err_v[k]) begin
        got_ack = ack_v[k]; got_err = err_v[k]; rd = rdata_v[k];
        break;
      end
    end
    req_v[k] = 1'b0;
    tick();
    check("no_repeat_resp", {30'd0, ack_v[k], err_v[k]}, 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    bit          e_ack;
    bit          e_err;
    bit          chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] model_mem [NI][16];

  initial begin
    bit          ga, ge, miss, wr;
    logic [31:0] rd, a, d, exp_word;
    logic [3:0]  s;
    int          lat, w, seen;

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'h9, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11ADBE44};
    vecs[4]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h55667788, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h55667788};
    vecs[7]  = '{1'b1, 32'h0000_0010, 4'h0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11ADBE44};
    vecs[9]  = '{1'b1, 32'h0000_0010, 4'h2, 32'h00009900, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        1'b1, 1'b0, 1'b1, 32'h11AD9944};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};

    for (int k = 0; k < NI; k++) begin
      req_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = 32'd0; sel_v[k] = 4'd0; wdata_v[k] = 32'd0;
    end

    // Reset held with a pending read on instance 0
    rst = 1'b0;
    req_v[0] = 1'b1; addr_v[0] = 32'h0000_0010;
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        check("reset_ack",   {31'd0, ack_v[k]}, 32'd0);
        check("reset_err",   {31'd0, err_v[k]}, 32'd0);
        check("reset_rdata", rdata_v[k], 32'd0);
      end
    end
    rst = 1'b1;
    do_txn(0, 1'b0, 32'h0000_0010, 4'hF, 32'd0, ga, ge, rd, lat);
    check("first_ack", {31'd0, ga}, 32'd1);
    check("first_latency", lat, 32'(wait_of(0) + 1));

    // Directed table on the one-wait-state instance
    for (int i = 0; i < 12; i++) begin
      do_txn(0, vecs[i].wr, vecs[i].a, vecs[i].s, vecs[i].d, ga, ge, rd, lat);
      check($sformatf("vec%0d_ack", i), {31'd0, ga}, {31'd0, vecs[i].e_ack});
      check($sformatf("vec%0d_err", i), {31'd0, ge}, {31'd0, vecs[i].e_err});
      check($sformatf("vec%0d_latency", i), lat, 32'd2);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].e_rd);
    end

    // Abort: drop req after one wait state of a three-wait-state write
    do_txn(1, 1'b1, 32'h0000_0020, 4'hF, 32'h01020304, ga, ge, rd, lat);
    check("abort_pre_ack", {31'd0, ga}, 32'd1);
    we_v[1] = 1'b1; addr_v[1] = 32'h0000_0020; sel_v[1] = 4'hF; wdata_v[1] = 32'hCAFEF00D;
    req_v[1] = 1'b1;
    tick();
    tick();
    req_v[1] = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack_v[1] || err_v[1]) seen++;
    end
    check("abort_no_resp", seen, 32'd0);
    check("abort_state_idle", {30'd0, state_v[1]}, {30'd0, IDLE_CODE});
    do_txn(1, 1'b0, 32'h0000_0020, 4'hF, 32'd0, ga, ge, rd, lat);
    check("abort_read_ack", {31'd0, ga}, 32'd1);
    check("abort_read_latency", lat, 32'd4);
    check("abort_word_kept", rd, 32'h01020304);

    // Zero wait states: read held back-to-back acks every other cycle
    do_txn(2, 1'b1, 32'h0000_0040, 4'hF, 32'h0BADF00D, ga, ge, rd, lat);
    check("zw_write_latency", lat, 32'd1);
    we_v[2] = 1'b0; addr_v[2] = 32'h0000_0040; req_v[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("zw_ack_c%0d", c), {31'd0, ack_v[2]}, {31'd0, (c % 2) == 0});
      if (ack_v[2]) check($sformatf("zw_rdata_c%0d", c), rdata_v[2], 32'h0BADF00D);
    end
    req_v[2] = 1'b0;
    tick();

    // Reset during WAIT of a three-wait-state write
    do_txn(1, 1'b1, 32'h0000_0024, 4'hF, 32'hA5A5A5A5, ga, ge, rd, lat);
    we_v[1] = 1'b1; addr_v[1] = 32'h0000_0024; sel_v[1] = 4'hF; wdata_v[1] = 32'h5A5A5A5A;
    req_v[1] = 1'b1;
    tick();
    tick();
    check("midrst_in_wait", {31'd0, state_v[1] != IDLE_CODE}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_ack", {31'd0, ack_v[1]}, 32'd0);
    check("midrst_state_idle", {30'd0, state_v[1]}, {30'd0, IDLE_CODE});
    req_v[1] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    do_txn(1, 1'b0, 32'h0000_0024, 4'hF, 32'd0, ga, ge, rd, lat);
    check("midrst_read_ack", {31'd0, ga}, 32'd1);
    check("midrst_word_kept", rd, 32'hA5A5A5A5);

    // Randomized traffic against a word-array model, per instance
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) begin
        model_mem[k][i] = $urandom;
        do_txn(k, 1'b1, 32'h0000_0100 + 32'(4 * i), 4'hF, model_mem[k][i], ga, ge, rd, lat);
        check("rnd_init_ack", {31'd0, ga}, 32'd1);
      end
      for (int t = 0; t < 40; t++) begin
        miss = ($urandom_range(0, 7) == 0);
        w    = $urandom_range(0, 15);
        wr   = $urandom_range(0, 1) == 1;
        s    = 4'($urandom_range(0, 15));
        d    = $urandom;
        if (miss) a = ($urandom & 32'hFFFF_FFFF) | 32'h0000_1000;
        else      a = 32'h0000_0100 + 32'(4 * w) + 32'($urandom_range(0, 3));
        do_txn(k, wr, a, s, d, ga, ge, rd, lat);
        check("rnd_latency", lat, 32'(wait_of(k) + 1));
        check("rnd_ack", {31'd0, ga}, {31'd0, !miss});
        check("rnd_err", {31'd0, ge}, {31'd0, miss});
        if (!miss && wr) begin
          // byte offset o (0 = most significant) is written when sel[3-o] is set
          exp_word = model_mem[k][w];
          for (int o = 0; o < 4; o++)
            if (s[3-o]) exp_word[31-8*o -: 8] = d[31-8*o -: 8];
          model_mem[k][w] = exp_word;
        end else if (!miss) begin
          check("rnd_rdata", rd, model_mem[k][w]);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
